// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl shared definitions: status encodings and
// default geometry so memory, controller and benches agree.
package fifo_ctrl_pkg;

  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_WORD_SIZE = 10;
  localparam int DEF_PTR       = 3;
  localparam int DEF_AF_TH     = 6;
  localparam int DEF_AE_TH     = 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

endpackage

// File: rtl/ptr_counter.sv
// Enable-increment pointer; wraps through natural
// PTR-bit overflow.
module ptr_counter #(
  parameter int PTR = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [PTR-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller for the memory block.
// FIFO_CTRL_ERR_STICKY_EN: error and ERR state hold until reset.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR,
  parameter int AF_TH     = DEF_AF_TH,
  parameter int AE_TH     = DEF_AE_TH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push_req,
  input  logic           pop_req,
  output logic           push,
  output logic           pop,
  output logic [PTR-1:0] wr_ptr,
  output logic [PTR-1:0] rd_ptr,
  output logic [PTR:0]   count,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           valid_out,
  output logic           error
);

  localparam int CW = PTR + 1;

  if (MEM_SIZE != (1 << PTR) || WORD_SIZE < 1)
  begin : g_bad_cfg
    $error("fifo_ctrl: MEM_SIZE must be 2**PTR");
  end

  logic         pop_acc;
  logic         push_acc;
  logic         err_cond;
  logic         err_d;
  logic [PTR:0] count_d;
  state_e       state_q;
  state_e       state_d;

  // No bypass: an empty FIFO rejects pop even with a push.
  assign pop_acc  = reset & pop_req & ~empty;
  assign push_acc = reset & push_req & (~full | pop_acc);
  assign push     = push_acc;
  assign pop      = pop_acc;

  assign err_cond = (push_req & ~push_acc)
                  | (pop_req & ~pop_acc);

  assign count_d = count
                 + {{PTR{1'b0}}, push_acc}
                 - {{PTR{1'b0}}, pop_acc};

`ifdef FIFO_CTRL_ERR_STICKY_EN
  assign err_d = error | err_cond;
`else
  assign err_d = err_cond;
`endif

  ptr_counter #(.PTR(PTR)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .en    (push_acc),
    .ptr   (wr_ptr)
  );

  ptr_counter #(.PTR(PTR)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .en    (pop_acc),
    .ptr   (rd_ptr)
  );

  // Flags come from next-count so they line up with count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      valid_out    <= 1'b0;
      error        <= 1'b0;
    end else begin
      count        <= count_d;
      full         <= count_d == CW'(MEM_SIZE);
      empty        <= count_d == '0;
      almost_full  <= count_d >= CW'(AF_TH);
      almost_empty <= count_d <= CW'(AE_TH);
      valid_out    <= pop_acc;
      error        <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (push_acc) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (count_d == '0) state_d = ST_IDLE;
      end
      ST_ERR: begin
`ifdef FIFO_CTRL_ERR_STICKY_EN
        state_d = ST_ERR;
`else
        state_d = (count_d == '0) ? ST_IDLE
                                  : ST_ACTIVE;
`endif
      end
    endcase
    if (err_cond) state_d = ST_ERR;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// fifo_ctrl bench: occupancy model, per-cycle compare,
// directed corner cases then randomized traffic.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push_req = 1'b0;
  logic       pop_req = 1'b0;
  logic       push;
  logic       pop;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       valid_out;
  logic       error;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  int m_count = 0;
  int m_wp    = 0;
  int m_rp    = 0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  bit m_pa;
  bit m_wa;
  bit m_ec;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .valid_out    (valid_out),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  function automatic bit f_pop();
    return reset && pop_req && (m_count > 0);
  endfunction

  function automatic bit f_push();
    return reset && push_req
        && ((m_count < DEPTH) || f_pop());
  endfunction

  // Reference: occupancy and pointers as plain integers.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count = 0;
      m_wp    = 0;
      m_rp    = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_pa = f_pop();
      m_wa = f_push();
      m_ec = (push_req && !m_wa) || (pop_req && !m_pa);
      m_count = m_count + int'(m_wa) - int'(m_pa);
      m_wp    = (m_wp + int'(m_wa)) % DEPTH;
      m_rp    = (m_rp + int'(m_pa)) % DEPTH;
      m_valid = m_pa;
`ifdef FIFO_CTRL_ERR_STICKY_EN
      m_err   = m_err || m_ec;
`else
      m_err   = m_ec;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("push", push, f_push());
      chk("pop", pop, f_pop());
      chk("wr_ptr", wr_ptr, m_wp);
      chk("rd_ptr", rd_ptr, m_rp);
      chk("count", count, m_count);
      chk("full", full, m_count == DEPTH);
      chk("empty", empty, m_count == 0);
      chk("almost_full", almost_full, m_count >= AFT);
      chk("almost_empty", almost_empty, m_count <= AET);
      chk("valid_out", valid_out, m_valid);
      chk("error", error, m_err);
    end
  end

  task automatic step(input bit pu, input bit po);
    push_req = pu;
    pop_req  = po;
    @(posedge clk);
    #1;
  endtask

  int pbias[5] = '{70, 30, 85, 15, 50};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_error", error, 0);
    chk("rst_push", push, 0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      step(1, 0);
      chk("fill_wr_ptr", wr_ptr, i % 8);
      if (i == 5) chk("af_at5", almost_full, 0);
      if (i == 6) chk("af_at6", almost_full, 1);
    end
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);

    push_req = 1'b1;
    pop_req  = 1'b0;
    #1;
    chk("push_at_full", push, 0);
    @(posedge clk);
    #1;
    chk("full_push_err", error, 1);
    chk("full_push_cnt", count, 8);
    chk("full_push_wp", wr_ptr, 0);

    step(1, 1);
    chk("full_pp_cnt", count, 8);
    chk("full_pp_valid", valid_out, 1);
    chk("full_pp_rp", rd_ptr, 1);

    for (int i = 0; i < 8; i++) begin
      step(0, 1);
      chk("drain_valid", valid_out, 1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_rp", rd_ptr, 1);

    push_req = 1'b0;
    pop_req  = 1'b1;
    #1;
    chk("pop_at_empty", pop, 0);
    @(posedge clk);
    #1;
    chk("empty_pop_err", error, 1);
    chk("empty_pop_valid", valid_out, 0);

    step(1, 1);
    chk("empty_pp_cnt", count, 1);
    chk("empty_pp_valid", valid_out, 0);

    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 120; c++) begin
        step($urandom_range(0, 99) < pbias[b],
             $urandom_range(0, 99) >= pbias[b]);
      end
    end

    push_req = 1'b0;
    pop_req  = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 1);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("mid_count5", count, 5);
`ifdef FIFO_CTRL_ERR_STICKY_EN
    chk("sticky_err_held", error, 1);
`else
    chk("pulse_err_gone", error, 0);
`endif
    push_req = 1'b1;
    reset    = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wp", wr_ptr, 0);
    chk("mid_rst_rp", rd_ptr, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_push", push, 0);
    chk("mid_rst_err", error, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
